// File: rtl/limn2600_bus_pkg.sv
// Shared types and defaults for the Limn2600 bus initiator.
package limn2600_bus_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DT = 1'b1;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 16;
endpackage

// File: rtl/limn2600_bus_arbiter.sv
// Two-way fetch/data arbiter; on contention the port not granted last time wins.
module limn2600_bus_arbiter
  import limn2600_bus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dt_req,
  input  logic take,
  output logic grant_id,
  output logic grant_valid
);
  // Reset value 0 gives the data port the first contended grant.
  logic favour_if;

  always_comb begin
    grant_valid = if_req | dt_req;
    if (if_req && dt_req) grant_id = favour_if ? PORT_IF : PORT_DT;
    else if (dt_req)      grant_id = PORT_DT;
    else                  grant_id = PORT_IF;
  end

  always_ff @(posedge clk) begin
    if (rst)                       favour_if <= 1'b0;
    else if (take && grant_valid)  favour_if <= (grant_id == PORT_DT);
  end
endmodule

// File: rtl/limn2600_bus_initiator.sv
// Limn2600 bus master: arbitrates fetch and load/store ports onto a single-word
// cs/we/addr/wdata bus, one access in flight, with alignment check and rdy timeout.
module limn2600_bus_initiator
  import limn2600_bus_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_ack,
  output logic                  if_err,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dt_req,
  input  logic                  dt_we,
  input  logic [31:0]           dt_addr,
  input  logic [DATA_WIDTH-1:0] dt_wdata,
  output logic                  dt_ack,
  output logic                  dt_err,
  output logic [DATA_WIDTH-1:0] dt_rdata,
  output logic                  bus_cs,
  output logic                  bus_we,
  output logic [31:0]           bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_rdy,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state;
  logic            grant_id;
  logic            grant_valid;
  logic            cur_port;
  logic            cur_we;
  logic [CW-1:0]   wait_cnt;
  logic [31:0]     sel_addr;
  logic            sel_we;

  limn2600_bus_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .dt_req      (dt_req),
    .take        (state == ST_IDLE),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign sel_addr = (grant_id == PORT_DT) ? dt_addr : if_addr;
  assign sel_we   = (grant_id == PORT_DT) && dt_we;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_port  <= PORT_IF;
      cur_we    <= 1'b0;
      wait_cnt  <= '0;
      bus_cs    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      dt_ack    <= 1'b0;
      dt_err    <= 1'b0;
      dt_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            cur_port  <= grant_id;
            cur_we    <= sel_we;
            bus_addr  <= sel_addr;
            bus_wdata <= sel_we ? dt_wdata : '0;
            wait_cnt  <= '0;
            if (sel_addr[1:0] != 2'b00) begin
              // Misaligned: answer with an error without touching the bus.
              state  <= ST_RESP;
              if_ack <= (grant_id == PORT_IF);
              if_err <= (grant_id == PORT_IF);
              dt_ack <= (grant_id == PORT_DT);
              dt_err <= (grant_id == PORT_DT);
            end else begin
              state  <= ST_ISSUE;
              bus_cs <= 1'b1;
              bus_we <= sel_we;
            end
          end
        end
        ST_ISSUE: begin
          bus_cs <= 1'b0;
          bus_we <= 1'b0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus_rdy) begin
            state    <= ST_RESP;
            if_ack   <= (cur_port == PORT_IF);
            dt_ack   <= (cur_port == PORT_DT);
            if_rdata <= (cur_port == PORT_IF) ? bus_rdata : '0;
            dt_rdata <= (cur_port == PORT_DT && !cur_we) ? bus_rdata : '0;
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES)) begin
            state  <= ST_RESP;
            if_ack <= (cur_port == PORT_IF);
            if_err <= (cur_port == PORT_IF);
            dt_ack <= (cur_port == PORT_DT);
            dt_err <= (cur_port == PORT_DT);
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ST_RESP: begin
          state    <= ST_IDLE;
          if_ack   <= 1'b0;
          if_err   <= 1'b0;
          if_rdata <= '0;
          dt_ack   <= 1'b0;
          dt_err   <= 1'b0;
          dt_rdata <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
